// File: rtl/tdes_sequencer.sv
// tdes_sequencer: Triple-DES (EDE) run as three passes
// through a single shared combinational DES core.
module tdes_sequencer #(
   parameter int CORE_WAIT = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        In_Valid,
   output logic        In_Ready,
   input  logic        Mode,
   input  logic [63:0] Key0,
   input  logic [63:0] Key1,
   input  logic [63:0] Key2,
   input  logic [63:0] Data_In,
   output logic        Out_Valid,
   input  logic        Out_Ready,
   output logic [63:0] Data_Out,
   output logic [63:0] Core_Key,
   output logic [63:0] Core_Data,
   input  logic [63:0] Core_Enc_Result,
   input  logic [63:0] Core_Dec_Result,
   output logic        Busy,
   output logic [1:0]  Pass_Idx
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(CORE_WAIT - 1);

   state_t      state;
   state_t      state_nx;
   logic [63:0] key0_q;
   logic [63:0] key1_q;
   logic [63:0] key2_q;
   logic        mode_q;
   logic [1:0]  pass_q;
   logic [3:0]  wait_q;
   logic [63:0] key0_nx;
   logic [63:0] key1_nx;
   logic [63:0] key2_nx;
   logic        mode_nx;
   logic [1:0]  pass_nx;
   logic [3:0]  wait_nx;
   logic [63:0] core_key_nx;
   logic [63:0] core_data_nx;
   logic [63:0] data_out_nx;
   logic        out_valid_nx;
   logic        wait_done;
   logic        enc_pass;
   logic [63:0] pass_res;
   logic [1:0]  pass_inc;

   // Mode 0 walks K0,K1,K2; mode 1 walks K2,K1,K0.
   function automatic logic [63:0] pick_key(
      input logic [1:0]  p,
      input logic        m,
      input logic [63:0] k0,
      input logic [63:0] k1,
      input logic [63:0] k2
   );
      logic [63:0] k;
      case (p)
         2'd0:    k = m ? k2 : k0;
         2'd1:    k = k1;
         default: k = m ? k0 : k2;
      endcase
      return k;
   endfunction

   // Middle pass runs opposite to the outer ones; mode flips all three.
   assign wait_done = (wait_q == WAIT_LAST);
   assign enc_pass  = ~((pass_q == 2'd1) ^ mode_q);
   assign pass_res  = enc_pass ? Core_Enc_Result : Core_Dec_Result;
   assign pass_inc  = pass_q + 2'd1;

   // Status decodes straight from state.
   assign In_Ready = (state == IDLE);
   assign Busy     = (state != IDLE);
   assign Pass_Idx = (state == RUN) ? pass_q : 2'd0;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and next values of every datapath register.
   always_comb begin
      state_nx     = state;
      key0_nx      = key0_q;
      key1_nx      = key1_q;
      key2_nx      = key2_q;
      mode_nx      = mode_q;
      pass_nx      = pass_q;
      wait_nx      = wait_q;
      core_key_nx  = Core_Key;
      core_data_nx = Core_Data;
      data_out_nx  = Data_Out;
      out_valid_nx = Out_Valid;
      unique case (state)
         IDLE: begin
            if (In_Valid) begin
               key0_nx      = Key0;
               key1_nx      = Key1;
               key2_nx      = Key2;
               mode_nx      = Mode;
               pass_nx      = 2'd0;
               wait_nx      = 4'd0;
               core_data_nx = Data_In;
               core_key_nx  = pick_key(2'd0, Mode,
                                       Key0, Key1, Key2);
               state_nx     = RUN;
            end
         end
         RUN: begin
            if (wait_done) begin
               wait_nx = 4'd0;
               if (pass_q == 2'd2) begin
                  data_out_nx  = pass_res;
                  out_valid_nx = 1'b1;
                  pass_nx      = 2'd0;
                  state_nx     = DONE;
               end else begin
                  pass_nx      = pass_inc;
                  core_data_nx = pass_res;
                  core_key_nx  = pick_key(pass_inc, mode_q,
                                          key0_q, key1_q,
                                          key2_q);
               end
            end else begin
               wait_nx = wait_q + 4'd1;
            end
         end
         DONE: begin
            if (Out_Ready) begin
               out_valid_nx = 1'b0;
               state_nx     = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath registers; reset abandons any block in flight.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         key0_q    <= '0;
         key1_q    <= '0;
         key2_q    <= '0;
         mode_q    <= 1'b0;
         pass_q    <= 2'd0;
         wait_q    <= 4'd0;
         Core_Key  <= '0;
         Core_Data <= '0;
         Data_Out  <= '0;
         Out_Valid <= 1'b0;
      end else begin
         key0_q    <= key0_nx;
         key1_q    <= key1_nx;
         key2_q    <= key2_nx;
         mode_q    <= mode_nx;
         pass_q    <= pass_nx;
         wait_q    <= wait_nx;
         Core_Key  <= core_key_nx;
         Core_Data <= core_data_nx;
         Data_Out  <= data_out_nx;
         Out_Valid <= out_valid_nx;
      end
   end

endmodule
